gain_config_rx: RTL and testbench
=================================

GAIN_CONFIG_RX -- requirements
Module: gain_config_rx

Interface
REQ-001 SHALL have parameter GAIN_A1_RST, default 0, meaning o_gainA1 value held in reset (range 0-3).
REQ-002 SHALL have parameter GAIN_A2_RST, default 0, meaning o_gainA2 value held in reset (range 0-7).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 64, meaning i_mainclk cycles without a sclk rising edge before a partial frame is aborted.
REQ-004 SHALL have port i_mainclk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_sclk  input  1  serial clock from FPGA, asynchronous to i_mainclk, idles high.
REQ-007 SHALL have port i_sdin  input  1  serial data from FPGA, changes on i_sclk falling edge.
REQ-008 SHALL have port i_rearm  input  1  single-cycle request to accept a new frame.
REQ-009 SHALL have port o_gainA1  output  2  amplifier 1 gain code.
REQ-010 SHALL have port o_gainA2  output  3  amplifier 2 gain code.
REQ-011 SHALL have port o_ready  output  1  high when a complete frame has been applied.
REQ-012 SHALL have port o_busy  output  1  high while a frame is partially received.
REQ-013 SHALL have port o_frame_err  output  1  sticky timeout flag.

Function
REQ-014 SHALL pass i_sclk and i_sdin through identical 2-flop synchronizers plus one edge-history flop; sclk rise = history 0, synced 1.
REQ-015 SHALL sample synced sdin on the same i_mainclk edge that detects a sclk rise; supported i_sclk frequency <= i_mainclk/8.
REQ-016 SHALL use a 5-bit frame, LSB first: gainA1[0], gainA1[1], gainA2[0], gainA2[1], gainA2[2].
REQ-017 SHALL implement states WAIT, SHIFT, LOAD, DONE; reset state WAIT.
REQ-018 WAIT: first sclk rise shifts bit 0, bit count=1, -> SHIFT; o_busy=1 in SHIFT only.
REQ-019 SHIFT: each sclk rise shifts one bit; the rise that makes bit count 5 -> LOAD.
REQ-020 LOAD: one cycle; on its exit edge o_gainA1/o_gainA2 take shift register contents, o_ready<=1, -> DONE.
REQ-021 Outputs SHALL update exactly 2 i_mainclk cycles after the cycle detecting the 5th rise; gains never change at any other time.
REQ-022 DONE: sclk rises ignored; gains and o_ready held; i_rearm -> WAIT, o_ready<=0, gains held.
REQ-023 i_rearm in WAIT or SHIFT SHALL clear bit count and o_frame_err and go to WAIT; i_rearm coincident with a sclk rise: rearm wins, bit discarded.
REQ-024 i_rearm in LOAD SHALL be ignored (LOAD completes).

Reset
REQ-025 On i_reset=1, immediately: state WAIT, bit count 0, shift register 0, o_gainA1=GAIN_A1_RST, o_gainA2=GAIN_A2_RST, o_ready=0, o_busy=0, o_frame_err=0.
REQ-026 sclk synchronizer and history flops SHALL reset to 1 so release of reset with i_sclk high yields no false edge.
REQ-027 Reset mid-frame SHALL discard the partial frame; deassertion needs no sclk activity.

Configuration
REQ-028 With FRAME_TIMEOUT_EN defined: in SHIFT an idle counter counts cycles without sclk rise, cleared on each rise; at TIMEOUT_CYC -> WAIT, bit count 0, o_frame_err<=1 until i_rearm or reset; gains unchanged.
REQ-029 Without FRAME_TIMEOUT_EN: no idle counter, SHIFT waits indefinitely, o_frame_err tied 0.

Structure
REQ-030 Shared package gain_config_pkg SHALL hold the state encoding, FRAME_BITS=5, and gain widths 2 and 3.
REQ-031 One sub-module sync2 (2-flop synchronizer, reset-value parameter) SHALL be instantiated for i_sclk and i_sdin.

Verification
REQ-032 Frame bits 1,0,1,0,1 at sclk=mainclk/32 -> o_gainA1=1, o_gainA2=5, o_ready=1 two cycles after 5th rise detect.
REQ-033 Six sclk pulses after DONE -> gains stay 1/5; i_rearm then frame 1,1,1,1,1 -> gains 3/7, o_ready low between frames.
REQ-034 i_reset pulse after 3 bits -> gains GAIN_A1_RST/GAIN_A2_RST, o_busy=0; next full frame decodes correctly.
REQ-035 FRAME_TIMEOUT_EN, 2 bits then sclk idle 64 cycles -> o_frame_err=1, state WAIT, gains unchanged; i_rearm clears flag.
REQ-036 i_rearm coincident with 4th sclk rise -> bit count 0, subsequent 5-bit frame decodes correctly.

Source files
------------

// File: rtl/gain_config_pkg.sv
// rtl/gain_config_pkg.sv - shared encodings and widths for the gain configuration receiver
// Contents: FSM state encoding, frame length, gain code widths.
package gain_config_pkg;

    localparam int FRAME_BITS = 5;
    localparam int GAIN_A1_W  = 2;
    localparam int GAIN_A2_W  = 3;
    localparam int BIT_CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/gain_config_rx_if.sv
// rtl/gain_config_rx_if.sv - serial link and gain output bundle for gain_config_rx
// Signals: i_sclk/i_sdin serial link, i_rearm request, o_gainA1/o_gainA2 gain codes,
//          o_ready/o_busy/o_frame_err status.
// Modports: slave = receiver (gain_config_rx), master = link driver / observer.
import gain_config_pkg::*;

interface gain_config_rx_if;
    logic                 i_sclk;
    logic                 i_sdin;
    logic                 i_rearm;
    logic [GAIN_A1_W-1:0] o_gainA1;
    logic [GAIN_A2_W-1:0] o_gainA2;
    logic                 o_ready;
    logic                 o_busy;
    logic                 o_frame_err;

    modport slave (
        input  i_sclk, i_sdin, i_rearm,
        output o_gainA1, o_gainA2, o_ready, o_busy, o_frame_err
    );

    modport master (
        output i_sclk, i_sdin, i_rearm,
        input  o_gainA1, o_gainA2, o_ready, o_busy, o_frame_err
    );
endinterface

// File: rtl/gain_config_rx_sync2.sv
// rtl/gain_config_rx_sync2.sv - two-flop synchronizer with configurable reset value
// Ports: clk, rst (async active-high), d (asynchronous input), q (synchronized output).
// Parameter: RST_VAL - value both flops take in reset.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gain_config_rx.sv
// rtl/gain_config_rx.sv - receives a 5-bit LSB-first serial frame and applies amplifier gain codes
// Ports: i_mainclk (sole clock), i_reset (async active-high), bus (gain_config_rx_if.slave:
//        i_sclk, i_sdin, i_rearm in; o_gainA1, o_gainA2, o_ready, o_busy, o_frame_err out).
// Parameters: GAIN_A1_RST, GAIN_A2_RST (gain codes held in reset), TIMEOUT_CYC (idle abort limit).
// Build option: FRAME_TIMEOUT_EN enables the partial-frame idle timeout and o_frame_err.
import gain_config_pkg::*;

module gain_config_rx #(
    parameter int GAIN_A1_RST = 0,
    parameter int GAIN_A2_RST = 0,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              i_mainclk,
    input  logic              i_reset,
    gain_config_rx_if.slave   bus
);

    logic                  sclk_s;
    logic                  sdin_s;
    logic                  sclk_hist;
    logic                  sclk_rise;
    state_t                state;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [FRAME_BITS-1:0] sreg;
    logic [GAIN_A1_W-1:0]  gain_a1;
    logic [GAIN_A2_W-1:0]  gain_a2;
    logic                  ready;
    logic                  busy;

    // sclk idles high, so its flops reset high: releasing reset with sclk high is not an edge.
    sync2 #(.RST_VAL(1'b1)) u_sync_sclk (.clk(i_mainclk), .rst(i_reset), .d(bus.i_sclk), .q(sclk_s));
    sync2 #(.RST_VAL(1'b0)) u_sync_sdin (.clk(i_mainclk), .rst(i_reset), .d(bus.i_sdin), .q(sdin_s));

    always_ff @(posedge i_mainclk or posedge i_reset) begin
        if (i_reset) sclk_hist <= 1'b1;
        else         sclk_hist <= sclk_s;
    end

    assign sclk_rise = sclk_s & ~sclk_hist;

`ifdef FRAME_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    logic [IDLE_W-1:0] idle_cnt;
    logic              frame_err;
`endif

    always_ff @(posedge i_mainclk or posedge i_reset) begin
        if (i_reset) begin
            state   <= ST_WAIT;
            bit_cnt <= '0;
            sreg    <= '0;
            gain_a1 <= GAIN_A1_W'(GAIN_A1_RST);
            gain_a2 <= GAIN_A2_W'(GAIN_A2_RST);
            ready   <= 1'b0;
            busy    <= 1'b0;
`ifdef FRAME_TIMEOUT_EN
            idle_cnt  <= '0;
            frame_err <= 1'b0;
`endif
        end else begin
            case (state)
                ST_WAIT: begin
                    if (bus.i_rearm) begin
                        bit_cnt <= '0;
`ifdef FRAME_TIMEOUT_EN
                        frame_err <= 1'b0;
`endif
                    end else if (sclk_rise) begin
                        // LSB arrives first, so shifting right leaves bit 0 in sreg[0].
                        sreg    <= {sdin_s, sreg[FRAME_BITS-1:1]};
                        bit_cnt <= BIT_CNT_W'(1);
                        busy    <= 1'b1;
                        state   <= ST_SHIFT;
`ifdef FRAME_TIMEOUT_EN
                        idle_cnt <= '0;
`endif
                    end
                end
                ST_SHIFT: begin
                    if (bus.i_rearm) begin
                        // Rearm takes priority over a coincident sclk rise; that bit is dropped.
                        bit_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= ST_WAIT;
`ifdef FRAME_TIMEOUT_EN
                        frame_err <= 1'b0;
`endif
                    end else if (sclk_rise) begin
                        sreg    <= {sdin_s, sreg[FRAME_BITS-1:1]};
                        bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        if (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)) begin
                            busy  <= 1'b0;
                            state <= ST_LOAD;
                        end
`ifdef FRAME_TIMEOUT_EN
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)) begin
                        bit_cnt   <= '0;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                        state     <= ST_WAIT;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
`endif
                    end
                end
                ST_LOAD: begin
                    gain_a1 <= sreg[GAIN_A1_W-1:0];
                    gain_a2 <= sreg[FRAME_BITS-1:GAIN_A1_W];
                    ready   <= 1'b1;
                    bit_cnt <= '0;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.i_rearm) begin
                        ready <= 1'b0;
                        state <= ST_WAIT;
                    end
                end
                default: state <= ST_WAIT;
            endcase
        end
    end

    assign bus.o_gainA1 = gain_a1;
    assign bus.o_gainA2 = gain_a2;
    assign bus.o_ready  = ready;
    assign bus.o_busy   = busy;
`ifdef FRAME_TIMEOUT_EN
    assign bus.o_frame_err = frame_err;
`else
    assign bus.o_frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_gain_config_rx.sv
// tb/tb_gain_config_rx.sv - self-checking bench for gain_config_rx with randomized frames
module tb_gain_config_rx;

    localparam int A1_RST = 2;
    localparam int A2_RST = 6;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   exp_a1;
    int   exp_a2;

    gain_config_rx_if bus ();

    gain_config_rx #(
        .GAIN_A1_RST(A1_RST),
        .GAIN_A2_RST(A2_RST),
        .TIMEOUT_CYC(64)
    ) dut (
        .i_mainclk(clk),
        .i_reset  (rst),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_gains(input string tag);
        check({tag, "_a1"}, int'(bus.o_gainA1), exp_a1);
        check({tag, "_a2"}, int'(bus.o_gainA2), exp_a2);
    endtask

    // sclk period is 32 mainclk cycles; sdin changes with the falling edge.
    task automatic send_bit(input int b);
        @(negedge clk);
        bus.i_sclk = 1'b0;
        bus.i_sdin = b[0];
        repeat (16) @(negedge clk);
        bus.i_sclk = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    task automatic pulse_rearm();
        @(negedge clk);
        bus.i_rearm = 1'b1;
        @(negedge clk);
        bus.i_rearm = 1'b0;
    endtask

    // Sends frame value f LSB first; checks the exact update latency after the 5th rise.
    // sclk goes high just before edge P1; it is seen synced after P2, detected up to P3,
    // LOAD occupies P3..P4, so outputs must be stable-old through P3 and new after P4.
    task automatic send_frame(input string tag, input int f);
        for (int i = 0; i < 4; i++) send_bit((f >> i) & 1);
        @(negedge clk);
        bus.i_sclk = 1'b0;
        bus.i_sdin = (f >> 4) & 1;
        repeat (16) @(negedge clk);
        bus.i_sclk = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check({tag, "_early_ready"}, int'(bus.o_ready), 0);
            check_gains({tag, "_early"});
        end
        exp_a1 = f % 4;
        exp_a2 = f / 4;
        @(negedge clk);
        check({tag, "_ready"}, int'(bus.o_ready), 1);
        check_gains(tag);
        check({tag, "_busy"}, int'(bus.o_busy), 0);
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int f;
        rst         = 1'b1;
        bus.i_sclk  = 1'b1;
        bus.i_sdin  = 1'b0;
        bus.i_rearm = 1'b0;
        exp_a1      = A1_RST;
        exp_a2      = A2_RST;

        repeat (3) @(negedge clk);
        check_gains("reset");
        check("reset_ready", int'(bus.o_ready), 0);
        check("reset_busy", int'(bus.o_busy), 0);
        check("reset_err", int'(bus.o_frame_err), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_busy", int'(bus.o_busy), 0);

        // bits 1,0,1,0,1 -> gainA1=1, gainA2=5
        send_frame("frame_10101", 5'b10101);

        // sclk activity in DONE is ignored
        for (int i = 0; i < 6; i++) send_bit(i & 1);
        check_gains("done_ignore");
        check("done_ready", int'(bus.o_ready), 1);

        pulse_rearm();
        @(negedge clk);
        check("rearm_ready", int'(bus.o_ready), 0);
        check_gains("rearm_hold");
        send_frame("frame_11111", 5'b11111);

        for (int n = 0; n < 4; n++) begin
            pulse_rearm();
            f = int'($urandom_range(0, 31));
            send_frame("rand_frame", f);
        end

        // reset after 3 bits discards the partial frame
        pulse_rearm();
        for (int i = 0; i < 3; i++) send_bit(int'($urandom_range(0, 1)));
        check("partial_busy", int'(bus.o_busy), 1);
        @(negedge clk);
        rst = 1'b1;
        exp_a1 = A1_RST;
        exp_a2 = A2_RST;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_gains("midreset");
        check("midreset_busy", int'(bus.o_busy), 0);
        check("midreset_ready", int'(bus.o_ready), 0);
        f = int'($urandom_range(0, 31));
        send_frame("post_reset_frame", f);

        // rearm coincident with the detection of the 4th rise
        pulse_rearm();
        for (int i = 0; i < 3; i++) send_bit(1);
        @(negedge clk);
        bus.i_sclk = 1'b0;
        repeat (16) @(negedge clk);
        bus.i_sclk = 1'b1;
        repeat (2) @(negedge clk);
        bus.i_rearm = 1'b1;
        @(negedge clk);
        bus.i_rearm = 1'b0;
        check("coincident_busy", int'(bus.o_busy), 0);
        repeat (16) @(negedge clk);
        check("coincident_busy_late", int'(bus.o_busy), 0);
        check_gains("coincident_hold");
        f = int'($urandom_range(0, 31));
        send_frame("post_coincident_frame", f);

        // partial frame left idle
        pulse_rearm();
        send_bit(1);
        send_bit(0);
        repeat (30) @(negedge clk);
        check("idle_short_busy", int'(bus.o_busy), 1);
        check("idle_short_err", int'(bus.o_frame_err), 0);
        repeat (40) @(negedge clk);
`ifdef FRAME_TIMEOUT_EN
        check("timeout_err", int'(bus.o_frame_err), 1);
        check("timeout_busy", int'(bus.o_busy), 0);
        check_gains("timeout_hold");
        pulse_rearm();
        @(negedge clk);
        check("timeout_err_cleared", int'(bus.o_frame_err), 0);
`else
        repeat (100) @(negedge clk);
        check("no_timeout_busy", int'(bus.o_busy), 1);
        check("no_timeout_err", int'(bus.o_frame_err), 0);
        check_gains("no_timeout_hold");
        pulse_rearm();
        @(negedge clk);
        check("no_timeout_rearm_busy", int'(bus.o_busy), 0);
`endif
        f = int'($urandom_range(0, 31));
        send_frame("final_frame", f);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
